// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter driving a SETUP/STROBE/RELEASE strobe sequence into a bit RAM.
// Ack is issued 3 cycles after grant; one access per 4 cycles; requesters hold req until they see ack.
module ram_arbiter #(
  parameter int WORD     = 1,
  parameter int SIZE_LOG = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                we0,
  input  logic [SIZE_LOG-1:0] addr0,
  input  logic [WORD-1:0]     wdata0,
  input  logic                req1,
  input  logic                we1,
  input  logic [SIZE_LOG-1:0] addr1,
  input  logic [WORD-1:0]     wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic [WORD-1:0]     rdata0,
  output logic [WORD-1:0]     rdata1,
  output logic                busy,
  output logic                ram_read,
  output logic                ram_write,
  output logic [SIZE_LOG-1:0] ram_address,
  output logic [WORD-1:0]     ram_data_in,
  input  logic [WORD-1:0]     ram_data_out
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t state;
  logic   last_grant;
  logic   gnt;
  logic   lat_we;
  logic   grant_sel;

  // On a tie the port not served last time wins; otherwise the lone requester wins.
  always_comb begin
    grant_sel = req1;
    if (req0 && req1) grant_sel = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      lat_we      <= 1'b0;
      busy        <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt         <= grant_sel;
            last_grant  <= grant_sel;
            lat_we      <= grant_sel ? we1 : we0;
            // The address/data pins double as the latched request fields and hold after release.
            ram_address <= grant_sel ? addr1 : addr0;
            ram_data_in <= grant_sel ? wdata1 : wdata0;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          ram_write <= lat_we;
          ram_read  <= ~lat_we;
          state     <= STROBE;
        end
        STROBE: begin
          if (!lat_we) begin
            if (gnt) rdata1 <= ram_data_out;
            else     rdata0 <= ram_data_out;
          end
          ack0  <= ~gnt;
          ack1  <= gnt;
          state <= RELEASE;
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized self-checking bench for ram_arbiter with a behavioural bit RAM.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, addr1;
  logic [0:0] wdata0, wdata1;
  logic       ack0, ack1, busy, ram_read, ram_write;
  logic [0:0] rdata0, rdata1, ram_data_in, ram_data_out;
  logic [7:0] ram_address;

  logic [0:0] mem [256];
  logic [0:0] exp_mem [256];
  logic       mem_clr;
  int         rd_pulses = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WORD(1), .SIZE_LOG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Behavioural RAM: write on strobe, asynchronous read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ram_write) begin
      mem[ram_address] <= ram_data_in;
    end
    if (ram_read) rd_pulses <= rd_pulses + 1;
  end
  assign ram_data_out = mem[ram_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one access from IDLE, returns cycles until ack, then lets the FSM return to IDLE.
  task automatic access(input int p, input logic w, input logic [7:0] a, input logic d, output int lat);
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    lat = 0;
    do begin
      tick;
      lat++;
    end while (!((p == 0) ? ack0 : ack1) && lat < 12);
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
  endtask

  initial begin
    int lat;
    int ack_port[$];
    int ack_tick[$];
    int strobe_tick[$];
    int seen;
    logic       preq [2];
    logic       pwe [2];
    logic [7:0] pa [2];
    logic [0:0] pd [2];
    int         age [2];
    logic       prev_busy;
    logic [7:0] held_a;
    logic [0:0] held_d;
    int         done;
    int         cyc;
    logic       a_now;
    logic [0:0] r_now;

    rst_n = 1'b0; mem_clr = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    tick; tick;
    mem_clr = 1'b0;
    check("rst_ram_read", ram_read, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_ram_data_in", ram_data_in, 0);
    check("rst_acks", {ack1, ack0}, 0);
    check("rst_rdata", {rdata1, rdata0}, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick;

    // Port 0 write 0x2A = 1, cycle by cycle.
    req0 = 1; we0 = 1; addr0 = 8'h2A; wdata0 = 1;
    tick;
    check("wr_setup_busy", busy, 1);
    check("wr_setup_strobes", {ram_read, ram_write}, 0);
    check("wr_setup_addr", ram_address, 8'h2A);
    check("wr_setup_data", ram_data_in, 1);
    tick;
    check("wr_strobe_strobes", {ram_read, ram_write}, 2'b01);
    check("wr_strobe_addr", ram_address, 8'h2A);
    check("wr_strobe_ack", {ack1, ack0}, 0);
    tick;
    check("wr_release_ack", {ack1, ack0}, 2'b01);
    check("wr_release_strobes", {ram_read, ram_write}, 0);
    check("wr_release_addr", ram_address, 8'h2A);
    req0 = 0;
    tick;
    check("wr_idle_ack", {ack1, ack0}, 0);
    check("wr_idle_busy", busy, 0);
    check("wr_idle_addr_held", ram_address, 8'h2A);

    // Port 0 read back.
    seen = rd_pulses;
    access(0, 1'b0, 8'h2A, 1'b0, lat);
    check("rd_latency", lat, 3);
    check("rd_rdata0", rdata0, 1);
    check("rd_pulse_count", rd_pulses - seen, 1);

    // Contention with both requests present across reset release.
    rst_n = 0;
    req0 = 1; we0 = 0; addr0 = 8'h30;
    req1 = 1; we1 = 0; addr1 = 8'h31;
    tick; tick;
    rst_n = 1;
    for (int i = 1; i <= 16; i++) begin
      tick;
      if (ack0) begin ack_port.push_back(0); ack_tick.push_back(i); end
      if (ack1) begin ack_port.push_back(1); ack_tick.push_back(i); end
      if (ram_read) strobe_tick.push_back(i);
    end
    req0 = 0; req1 = 0;
    check("cont_ack_count", ack_port.size(), 4);
    check("cont_strobe_count", strobe_tick.size(), 4);
    if (ack_port.size() == 4 && strobe_tick.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("cont_ack_port", ack_port[i], i % 2);
        check("cont_ack_tick", ack_tick[i], 3 + 4 * i);
      end
      check("cont_strobe_gap", strobe_tick[1] - strobe_tick[0], 4);
    end
    tick;

    // Field change after grant is ignored.
    access(0, 1'b1, 8'h11, 1'b1, lat);
    req1 = 1; we1 = 0; addr1 = 8'h10;
    tick;
    addr1 = 8'h11;
    check("fld_setup_addr", ram_address, 8'h10);
    tick;
    check("fld_strobe_addr", ram_address, 8'h10);
    check("fld_strobe_read", ram_read, 1);
    tick;
    check("fld_ack1", ack1, 1);
    check("fld_release_addr", ram_address, 8'h10);
    check("fld_rdata1", rdata1, 0);
    req1 = 0;
    tick;

    // rdata isolation between ports.
    access(0, 1'b0, 8'h2A, 1'b0, lat);
    check("iso_rdata0_pre", rdata0, 1);
    access(1, 1'b1, 8'h05, 1'b1, lat);
    access(1, 1'b0, 8'h05, 1'b0, lat);
    check("iso_rdata1_read", rdata1, 1);
    access(0, 1'b1, 8'h05, 1'b0, lat);
    check("iso_rdata1_after_wr", rdata1, 1);
    check("iso_rdata0_after_wr", rdata0, 1);
    access(1, 1'b0, 8'h05, 1'b0, lat);
    check("iso_rdata1_reread", rdata1, 0);

    // Reset during STROBE of a write.
    req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 1;
    tick; tick;
    check("rsw_strobe_write", ram_write, 1);
    rst_n = 0; req0 = 0;
    tick;
    check("rsw_write", ram_write, 0);
    check("rsw_read", ram_read, 0);
    check("rsw_busy", busy, 0);
    check("rsw_acks", {ack1, ack0}, 0);
    check("rsw_addr", ram_address, 0);
    check("rsw_data", ram_data_in, 0);
    check("rsw_rdata", {rdata1, rdata0}, 0);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (ack0 || ack1) seen++;
    end
    check("rsw_no_ack", seen, 0);

    // Random traffic with protocol checks.
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    for (int p = 0; p < 2; p++) begin
      preq[p] = 0; pwe[p] = 0; pa[p] = 0; pd[p] = 0; age[p] = 0;
    end
    prev_busy = 0; held_a = 0; held_d = 0; done = 0; cyc = 0;
    while (done < 1000 && cyc < 20000) begin
      tick;
      cyc++;
      check("p_strobe_excl", ram_read & ram_write, 0);
      check("p_ack_excl", ack0 & ack1, 0);
      if (busy && prev_busy) begin
        check("p_addr_stable", ram_address, held_a);
        check("p_data_stable", ram_data_in, held_d);
      end else if (busy) begin
        held_a = ram_address;
        held_d = ram_data_in;
      end
      prev_busy = busy;
      for (int p = 0; p < 2; p++) begin
        a_now = (p == 0) ? ack0 : ack1;
        r_now = (p == 0) ? rdata0 : rdata1;
        if (preq[p]) age[p]++;
        if (preq[p] && a_now) begin
          check("p_ack_latency", age[p] <= 8, 1);
          if (pwe[p]) exp_mem[pa[p]] = pd[p];
          else        check("p_rdata", r_now, exp_mem[pa[p]]);
          preq[p] = 0;
          done++;
        end else if (!preq[p] && $urandom_range(0, 2) == 0) begin
          preq[p] = 1;
          pwe[p]  = 1'($urandom_range(0, 1));
          pa[p]   = 8'($urandom_range(0, 255));
          pd[p]   = 1'($urandom_range(0, 1));
          age[p]  = 0;
        end else if (preq[p]) begin
          check("p_wait_bound", age[p] <= 8, 1);
        end
      end
      req0 = preq[0]; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0];
      req1 = preq[1]; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1];
    end
    check("p_done", done, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port sequencer and arbiter in front of the strobe-controlled bit RAM. It accepts independent access requests from the MC14500B core (port 0) and from the I/O/debug side (port 1). It grants them round-robin and converts each granted request into a clean SETUP/STROBE/RELEASE strobe sequence on the RAM's read/write/address/data pins. It returns a single-cycle acknowledge and, for reads, the captured data word.

## Interface
Parameters:
- WORD, 1, RAM data width in bits
- SIZE_LOG, 8, RAM address width; RAM depth is 2**SIZE_LOG

Ports:
- clk, input, 1, single system clock; all state changes on rising edge
- rst_n, input, 1, synchronous active-low reset, sampled on rising edge of clk
- req0 / req1, input, 1, access request from port 0 / port 1
- we0 / we1, input, 1, 1 = write, 0 = read, for port 0 / port 1
- addr0 / addr1, input, SIZE_LOG, access address
- wdata0 / wdata1, input, WORD, write data
- ack0 / ack1, output, 1, one-cycle completion pulse
- rdata0 / rdata1, output, WORD, read result, per port
- busy, output, 1, high while an access is in flight (any state except IDLE)
- ram_read, output, 1, RAM read strobe
- ram_write, output, 1, RAM write strobe
- ram_address, output, SIZE_LOG, RAM address
- ram_data_in, output, WORD, RAM write data
- ram_data_out, input, WORD, RAM read data

## Operation
- FSM states: IDLE -> SETUP -> STROBE -> RELEASE -> IDLE. No other transitions except reset.
- **IDLE**
  - If req0 and/or req1 is high, grant one port.
  - Latch that port's we/addr/wdata into internal registers.
  - Go to SETUP.
  - With no request, stay in IDLE.
- **Arbitration**
  - A single requester always wins.
  - When both request, grant the port not granted last time (round-robin).
  - last_grant resets to 1, so port 0 wins the first tie.
  - last_grant updates only on grant.
- **SETUP**
  - ram_address and ram_data_in are driven from the latched values.
  - Both strobes are low.
- **STROBE**
  - Address and data are held.
  - ram_write = latched we; ram_read = not latched we.
  - Exactly one strobe is high, for exactly one cycle.
  - For reads, ram_data_out is registered into the granted port's rdata on the edge ending STROBE.
- **RELEASE**
  - Strobes are low; address and data are still held.
  - The granted port's ack is high for this single cycle.
- **Outputs between accesses**
  - ram_address and ram_data_in keep their last values in IDLE; they do not return to 0.
- **Requester rules**
  - Hold req until ack is seen.
  - Request fields are sampled only at grant; later changes are ignored.
  - Dropping req after grant does not cancel the access; the ack is still issued.
  - A req still high in the cycle after ack is treated as a new request.
- **rdata**
  - Each rdataN holds its value until the next read completes for that port.
  - Writes never change rdata.

## Timing
- Reset values: ram_read=0, ram_write=0, ram_address=0, ram_data_in=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, state=IDLE, last_grant=1.
- Latency from req sampled high in IDLE (edge t) to ack high: SETUP at t+1, STROBE at t+2, ack during cycle t+3. That is 3 cycles; RELEASE returns to IDLE at t+4.
- Throughput: one access per 4 cycles under continuous contention. Both ports are guaranteed service within 8 cycles of request.
- Strobe timing: address/data become stable one full cycle before the strobe rises and stay stable one full cycle after it falls.
- ram_read and ram_write are never high in the same cycle.
- Never more than one ack is high per cycle.
- Reset mid-access: rst_n low on any edge forces IDLE and all reset values on that edge.
  - The in-flight access is dropped with no ack.
  - If reset hits during STROBE of a write, the write strobe is cut; the RAM contents at that address are undefined.
- Requests present when rst_n releases are arbitrated from IDLE normally, with port 0 winning a tie.

## Test plan
- **Single write then read, port 0:** write addr=0x2A wdata=1, then read addr=0x2A.
  - ram_write pulses 1 cycle with ram_address=0x2A one cycle either side.
  - ack0 arrives 3 cycles after req.
  - The read returns rdata0=1, with ram_read pulsing once.
- **Contention from reset:** req0 and req1 both high in the same cycle after reset.
  - Port 0 is served first; port 1's STROBE follows 4 cycles after port 0's STROBE.
  - With both held continuously, grants alternate 0,1,0,1.
- **Field change after grant:** change addr1 from 0x10 to 0x11 in SETUP.
  - RAM sees 0x10 throughout; ack1 still fires.
- **rdata isolation:** port 1 reads addr 0x05 (=1), then port 0 writes 0 to 0x05.
  - rdata1 stays 1; rdata0 is unchanged.
- **Reset during STROBE:** assert rst_n=0 during STROBE of a write.
  - Next cycle: ram_write=0, busy=0, no ack, all outputs at reset values.
- **Protocol assertions over 1000 random requests:**
  - Never both strobes high.
  - Never both acks high.
  - Address and data stable from SETUP through RELEASE.
  - Each req eventually acked within 8 cycles.
